// File: rtl/counter_cfg_master_pkg.sv
// Shared types and default widths for the counter configuration master.
package counter_cfg_master_pkg;

  localparam int unsigned COUNTER_BITWIDTH_DEF = 8;
  localparam int unsigned ROUND_BITWIDTH_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_RUN,
    ST_RECOUNT,
    ST_DONE
  } cfg_master_state_e;

endpackage

// File: rtl/counter_cfg_master_if.sv
// Counter-side bus: config handshake, recount pulse, step enable and counter status.
interface counter_cfg_master_if
  import counter_cfg_master_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH = COUNTER_BITWIDTH_DEF
) ();

  logic                        config_valid_o;
  logic [COUNTER_BITWIDTH-1:0] config_counter_o;
  logic                        config_ready_i;
  logic                        recount_en_o;
  logic                        step_en_o;
  logic                        counter_ready_i;
  logic                        counter_overflow_i;

  modport master (
    output config_valid_o, config_counter_o, recount_en_o, step_en_o,
    input  config_ready_i, counter_ready_i, counter_overflow_i
  );

  modport slave (
    input  config_valid_o, config_counter_o, recount_en_o, step_en_o,
    output config_ready_i, counter_ready_i, counter_overflow_i
  );

endinterface

// File: rtl/counter_cfg_master.sv
// Counter configuration master: loads a target into the counter, gates step
// requests into step enables and sequences recounts over a number of rounds.
module counter_cfg_master
  import counter_cfg_master_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH = COUNTER_BITWIDTH_DEF,
  parameter int unsigned ROUND_BITWIDTH   = ROUND_BITWIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [COUNTER_BITWIDTH-1:0] target_i,
  input  logic [ROUND_BITWIDTH-1:0]   rounds_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [ROUND_BITWIDTH-1:0]   round_o,
  input  logic                        step_req_i,
  output logic                        step_ack_o,
  counter_cfg_master_if.master        cnt_if
);

  cfg_master_state_e           state_q, state_d;
  logic [COUNTER_BITWIDTH-1:0] target_q, target_d;
  logic [ROUND_BITWIDTH-1:0]   rounds_q, rounds_d;
  logic [ROUND_BITWIDTH-1:0]   round_q, round_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        valid_q, valid_d;
  logic                        recount_q, recount_d;
  logic                        last_round;

  assign last_round = (round_q == (rounds_q - 1'b1));

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    rounds_d  = rounds_q;
    round_d   = round_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    recount_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_CFG;
          target_d = target_i;
          // zero rounds means a single round
          rounds_d = (rounds_i == '0) ? ROUND_BITWIDTH'(1) : rounds_i;
          round_d  = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          valid_d  = 1'b1;
        end
      end
      ST_CFG: begin
        // hold the offer until the counter takes it
        if (valid_q && cnt_if.config_ready_i) state_d = ST_RUN;
        else                                  valid_d = 1'b1;
      end
      ST_RUN: begin
        // overflow wins over a simultaneous finish
        if (cnt_if.counter_overflow_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_if.counter_ready_i) begin
          if (last_round) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_RECOUNT;
            recount_d = 1'b1;
            round_d   = round_q + 1'b1;
          end
        end
      end
      ST_RECOUNT: state_d = ST_RUN;
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any job without done or err.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      rounds_q  <= '0;
      round_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      recount_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      rounds_q  <= rounds_d;
      round_q   <= round_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      recount_q <= recount_d;
    end
  end

  // Zero-latency step gating: a finishing or overflowing counter takes no step.
  always_comb begin
    cnt_if.step_en_o = (state_q == ST_RUN) && step_req_i &&
                       !cnt_if.counter_ready_i && !cnt_if.counter_overflow_i;
  end

  assign step_ack_o              = cnt_if.step_en_o;
  assign cnt_if.config_valid_o   = valid_q;
  assign cnt_if.config_counter_o = target_q;
  assign cnt_if.recount_en_o     = recount_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign err_o                   = err_q;
  assign round_o                 = round_q;

endmodule
